// File: rtl/pump_mc.sv
// Copy engine moving an IN and an OUT buffer between user memory and an exchannel window,
// decoupled by a word FIFO so one read and one write can be in flight together.
module pump_mc #(
  parameter int unsigned            DATA_W     = 32,
  parameter int unsigned            ADDR_W     = 32,
  parameter int unsigned            CH_W       = 4,
  parameter int unsigned            FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0]      CH_BASE    = 'hA000_0000,
  parameter logic [ADDR_W-1:0]      CH_STRIDE  = 'h0200_0000,
  parameter logic [ADDR_W-1:0]      OUT_OFF    = 'h0100_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode,
  input  logic [CH_W-1:0]   ch_id,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] in_size,
  input  logic [ADDR_W-1:0] out_addr,
  input  logic [ADDR_W-1:0] out_size,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_done
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LB    = $clog2(BYTES);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic [2:0] {IDLE, CHECK, PH_IN, PH_OUT, FIN, ABORT, ERR} state_t;

  state_t              state;
  logic                mode_q;
  logic [CH_W-1:0]     ch_q;
  logic [ADDR_W-1:0]   in_addr_q, in_size_q, out_addr_q, out_size_q;
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr, rd_left;
  logic                rd_out, wr_out;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       rp, wp;
  logic [CW-1:0]       count;

  logic [ADDR_W-1:0]   win, win_out, mask;
  logic                in_phase, rd_acc, wr_acc, fifo_nz;
  logic                rd_issue, wr_issue, bypass, push, pop, phase_end, drained, misaligned;

  always_comb begin
    win        = CH_BASE + ADDR_W'(ch_q) * CH_STRIDE;
    win_out    = win + OUT_OFF;
    mask       = ADDR_W'(BYTES - 1);
    misaligned = ((in_size_q & mask) != '0) || ((out_size_q & mask) != '0) ||
                 ((in_addr_q & mask) != '0) || ((out_addr_q & mask) != '0);
    in_phase   = (state == PH_IN) || (state == PH_OUT);
    rd_acc     = rd_done && rd_out;
    wr_acc     = wr_done && wr_out;
    fifo_nz    = (count != '0);
    rd_issue   = in_phase && !abort && !rd_out && (rd_left != '0) && (count < CW'(FIFO_DEPTH));
    // An empty FIFO forwards the word arriving this cycle straight to the write port.
    wr_issue   = in_phase && !abort && !wr_out && (fifo_nz || rd_acc);
    bypass     = wr_issue && !fifo_nz;
    push       = in_phase && !abort && rd_acc && !bypass;
    pop        = wr_issue && fifo_nz;
    phase_end  = in_phase && !abort && (rd_left == '0) && !rd_out && !fifo_nz && !wr_out;
    drained    = (!rd_out || rd_acc) && (!wr_out || wr_acc);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      ch_q       <= '0;
      in_addr_q  <= '0;
      in_size_q  <= '0;
      out_addr_q <= '0;
      out_size_q <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rd_left    <= '0;
      rd_out     <= 1'b0;
      wr_out     <= 1'b0;
      rp         <= '0;
      wp         <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_cnt  <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      if (rd_acc) rd_out <= 1'b0;
      if (wr_acc) begin
        wr_out    <= 1'b0;
        words_cnt <= words_cnt + ADDR_W'(1);
      end
      if (rd_issue) begin
        rd_en   <= 1'b1;
        rd_addr <= rd_ptr;
        rd_out  <= 1'b1;
        rd_ptr  <= rd_ptr + ADDR_W'(BYTES);
        rd_left <= rd_left - ADDR_W'(1);
      end
      if (wr_issue) begin
        wr_en   <= 1'b1;
        wr_addr <= wr_ptr;
        wr_data <= fifo_nz ? mem[rp] : rd_data;
        wr_out  <= 1'b1;
        wr_ptr  <= wr_ptr + ADDR_W'(BYTES);
      end
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: if (start) begin
          mode_q     <= mode;
          ch_q       <= ch_id;
          in_addr_q  <= in_addr;
          in_size_q  <= in_size;
          out_addr_q <= out_addr;
          out_size_q <= out_size;
          words_cnt  <= '0;
          busy       <= 1'b1;
          state      <= CHECK;
        end
        CHECK: begin
          if (abort) state <= ABORT;
          else if (misaligned) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else begin
            rd_ptr  <= mode_q ? win : in_addr_q;
            wr_ptr  <= mode_q ? in_addr_q : win;
            rd_left <= in_size_q >> LB;
            state   <= PH_IN;
          end
        end
        PH_IN: begin
          if (abort) state <= ABORT;
          else if (phase_end) begin
            rd_ptr  <= mode_q ? win_out : out_addr_q;
            wr_ptr  <= mode_q ? out_addr_q : win_out;
            rd_left <= out_size_q >> LB;
            state   <= PH_OUT;
          end
        end
        PH_OUT: begin
          if (abort) state <= ABORT;
          else if (phase_end) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        ABORT: if (drained) begin
          rp      <= '0;
          wp      <= '0;
          count   <= '0;
          rd_left <= '0;
          err     <= 1'b1;
          busy    <= 1'b0;
          state   <= ERR;
        end
        FIN:     state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pump_mc.sv
// Directed bench for pump_mc: memory responders with adjustable latency/freeze, per-scenario tasks.
module tb_pump_mc;

  logic        clk = 1'b0;
  logic        rstn, start, mode, abort;
  logic [3:0]  ch_id;
  logic [31:0] in_addr, in_size, out_addr, out_size;
  logic        busy, done, err;
  logic [31:0] words_cnt;
  logic        rd_en, rd_done, wr_en, wr_done;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;

  int errors = 0;
  int checks = 0;

  pump_mc #(.DATA_W(32), .ADDR_W(32), .CH_W(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .ch_id(ch_id),
    .in_addr(in_addr), .in_size(in_size), .out_addr(out_addr), .out_size(out_size),
    .abort(abort), .busy(busy), .done(done), .err(err), .words_cnt(words_cnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  bit          rd_freeze = 0, wr_freeze = 0;
  int          wr_lat = 0;
  bit          rd_pend = 0, wr_pend = 0;
  int          wr_wait = 0;
  logic [31:0] rd_pa;
  int          rd_cnt = 0, rd_req = 0, wr_req = 0;
  logic [31:0] rlog[$];
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];

  initial begin
    rd_done = 0; rd_data = '0;
    forever begin
      @(negedge clk);
      rd_done = 0;
      if (!rstn) rd_pend = 0;
      else begin
        if (rd_en) begin rd_pend = 1; rd_pa = rd_addr; rd_req++; rlog.push_back(rd_addr); end
        if (rd_pend && !rd_freeze) begin
          rd_done = 1; rd_data = mdat(rd_pa); rd_pend = 0; rd_cnt++;
        end
      end
    end
  end

  initial begin
    wr_done = 0;
    forever begin
      @(negedge clk);
      wr_done = 0;
      if (!rstn) wr_pend = 0;
      else begin
        if (wr_en) begin
          wr_pend = 1; wr_wait = wr_lat; wr_req++;
          wlog_a.push_back(wr_addr); wlog_d.push_back(wr_data);
        end
        if (wr_pend && !wr_freeze) begin
          if (wr_wait == 0) begin wr_done = 1; wr_pend = 0; end
          else wr_wait--;
        end
      end
    end
  end

  task automatic clear_logs();
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
    rd_cnt = 0; rd_req = 0; wr_req = 0;
  endtask

  task automatic start_cmd(input logic m, input logic [3:0] ch, input logic [31:0] ia, is, oa, os);
    @(negedge clk);
    mode = m; ch_id = ch; in_addr = ia; in_size = is; out_addr = oa; out_size = os;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_end(output bit got_done, output bit got_err);
    got_done = 0; got_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (done) begin got_done = 1; break; end
      if (err)  begin got_err = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 0; start = 0; abort = 0; mode = 0; ch_id = '0;
    in_addr = '0; in_size = '0; out_addr = '0; out_size = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, rd_en, wr_en} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got=%b want=00000", {busy, done, err, rd_en, wr_en});
    end
    checks++;
    if ({words_cnt, rd_addr, wr_addr, wr_data} !== 128'h0) begin
      errors++; $display("FAIL reset_bus got=%h want=0", {words_cnt, rd_addr, wr_addr, wr_data});
    end
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic check_pump_in_vector(input string tag);
    bit gd, ge;
    logic [31:0] ea[6], es[6];
    ea = '{32'hA200_0000, 32'hA200_0004, 32'hA200_0008, 32'hA200_000C, 32'hA300_0000, 32'hA300_0004};
    es = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h2000, 32'h2004};
    clear_logs();
    start_cmd(1'b0, 4'd1, 32'h1000, 32'd16, 32'h2000, 32'd8);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b want=1", tag, busy); end
    wait_end(gd, ge);
    checks++;
    if (gd !== 1'b1 || ge !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done got done=%b err=%b busy=%b want 1 0 0", tag, gd, ge, busy);
    end
    checks++;
    if (words_cnt !== 32'd6) begin errors++; $display("FAIL %s_words got=%0d want=6", tag, words_cnt); end
    checks++;
    if (wlog_a.size() != 6 || rlog.size() != 6) begin
      errors++; $display("FAIL %s_count got wr=%0d rd=%0d want 6 6", tag, wlog_a.size(), rlog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wlog_a[i] !== ea[i] || wlog_d[i] !== mdat(es[i]) || rlog[i] !== es[i]) begin
          errors++;
          $display("FAIL %s_xfer%0d got rd=%h wa=%h wd=%h want rd=%h wa=%h wd=%h",
                   tag, i, rlog[i], wlog_a[i], wlog_d[i], es[i], ea[i], mdat(es[i]));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b want=0", tag, done); end
  endtask

  task automatic test_pump_in();
    check_pump_in_vector("pump_in");
  endtask

  task automatic test_pump_out();
    bit gd, ge;
    clear_logs();
    start_cmd(1'b1, 4'd0, 32'h3000, 32'd8, 32'h4000, 32'd0);
    wait_end(gd, ge);
    checks++;
    if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL pump_out_done got done=%b err=%b want 1 0", gd, ge); end
    checks++;
    if (rlog.size() != 2 || wlog_a.size() != 2 || words_cnt !== 32'd2) begin
      errors++; $display("FAIL pump_out_count got rd=%0d wr=%0d words=%0d want 2 2 2", rlog.size(), wlog_a.size(), words_cnt);
    end else begin
      checks++;
      if (rlog[0] !== 32'hA000_0000 || rlog[1] !== 32'hA000_0004) begin
        errors++; $display("FAIL pump_out_rd got=%h,%h want=a0000000,a0000004", rlog[0], rlog[1]);
      end
      checks++;
      if (wlog_a[0] !== 32'h3000 || wlog_a[1] !== 32'h3004 ||
          wlog_d[0] !== mdat(32'hA000_0000) || wlog_d[1] !== mdat(32'hA000_0004)) begin
        errors++; $display("FAIL pump_out_wr got=%h:%h,%h:%h want=3000/3004 with source data",
                           wlog_a[0], wlog_d[0], wlog_a[1], wlog_d[1]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] ia[2], is[2];
    ia = '{32'h1000, 32'h1002};
    is = '{32'd6, 32'd8};
    for (int v = 0; v < 2; v++) begin
      clear_logs();
      start_cmd(1'b0, 4'd1, ia[v], is[v], 32'h2000, 32'd8);
      checks++;
      if (busy !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL misalign%0d_check got busy=%b err=%b want 1 0", v, busy, err);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL misalign%0d_err got err=%b busy=%b want 1 0", v, err, busy);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (err !== 1'b0 || rd_req != 0 || wr_req != 0) begin
        errors++; $display("FAIL misalign%0d_quiet got err=%b rd=%0d wr=%0d want 0 0 0", v, err, rd_req, wr_req);
      end
    end
  endtask

  task automatic test_stall();
    bit gd, ge, seen;
    int base;
    clear_logs();
    wr_freeze = 1;
    start_cmd(1'b0, 4'd2, 32'h5000, 32'd32, 32'h6000, 32'd0);
    seen = 0; base = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr_req > 0) begin seen = 1; base = rd_cnt; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen || base != 1) begin errors++; $display("FAIL stall_first got seen=%b reads=%0d want 1 1", seen, base); end
    repeat (20) @(negedge clk);
    checks++;
    if (rd_cnt - base != 4 || rd_req != 5 || wr_req != 1) begin
      errors++; $display("FAIL stall_fill got reads_after=%0d rd_req=%0d wr_req=%0d want 4 5 1", rd_cnt - base, rd_req, wr_req);
    end
    wr_freeze = 0;
    wait_end(gd, ge);
    checks++;
    if (gd !== 1'b1 || wlog_a.size() != 8 || words_cnt !== 32'd8) begin
      errors++; $display("FAIL stall_done got done=%b wr=%0d words=%0d want 1 8 8", gd, wlog_a.size(), words_cnt);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wlog_a[i] !== 32'hA400_0000 + 32'(4 * i) || wlog_d[i] !== mdat(32'h5000 + 32'(4 * i))) begin
          errors++; $display("FAIL stall_order%0d got=%h:%h want=%h:%h", i, wlog_a[i], wlog_d[i],
                             32'hA400_0000 + 32'(4 * i), mdat(32'h5000 + 32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_abort();
    bit gd, ge, seen;
    clear_logs();
    wr_freeze = 1;
    start_cmd(1'b0, 4'd1, 32'h1000, 32'd16, 32'h2000, 32'd8);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr_req > 0) begin seen = 1; rd_freeze = 1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || rd_req != 2 || wr_req != 1 || rd_cnt != 1) begin
      errors++; $display("FAIL abort_setup got seen=%b rd=%0d wr=%0d rdone=%0d want 1 2 1 1", seen, rd_req, wr_req, rd_cnt);
    end
    abort = 1;
    repeat (5) @(negedge clk);
    rd_freeze = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_wait got err=%b busy=%b want 0 1", err, busy);
    end
    wr_freeze = 0;
    wait_end(gd, ge);
    checks++;
    if (ge !== 1'b1 || gd !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_err got err=%b done=%b busy=%b want 1 0 0", ge, gd, busy);
    end
    abort = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_req != 2 || wr_req != 1) begin
      errors++; $display("FAIL abort_noreq got rd=%0d wr=%0d want 2 1", rd_req, wr_req);
    end
    check_pump_in_vector("post_abort");
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs();
    wr_lat = 2;
    start_cmd(1'b0, 4'd1, 32'h1000, 32'd16, 32'h2000, 32'd16);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (wr_en && wr_addr == 32'hA300_0000) begin seen = 1; break; end
      @(negedge clk);
    end
    rstn = 0;
    @(negedge clk);
    checks++;
    if (!seen || {busy, done, err, rd_en, wr_en} !== 5'b0 ||
        {words_cnt, rd_addr, wr_addr, wr_data} !== 128'h0) begin
      errors++; $display("FAIL reset_mid got seen=%b ctl=%b bus=%h want 1 00000 0", seen,
                         {busy, done, err, rd_en, wr_en}, {words_cnt, rd_addr, wr_addr, wr_data});
    end
    rstn = 1;
    wr_lat = 0;
    @(negedge clk);
    check_pump_in_vector("post_reset");
  endtask

  initial begin
    test_reset();
    test_pump_in();
    test_pump_out();
    test_misalign();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
